// File: rtl/bounded_count_sched.sv
// Two-requester round-robin scheduler that owns the bounded step counter
// (x/y/size). A granted job loads size from the winner's limit, steps the
// counter from x=1, y=0 until x passes size, then reports y with a done pulse.
module bounded_count_sched #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RESET_SIZE = 230
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] lim0,
    input  logic             req1,
    input  logic [WIDTH-1:0] lim1,
    input  logic             step_en,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH:0]   x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] size
);

    // x carries one extra bit so a full-scale limit terminates without wrapping
    localparam int unsigned XW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             rr_ptr;
    logic             rr_next;
    logic             owner;
    logic             owner_next;
    logic             win;
    logic             x_over;

    logic [XW-1:0]    x_next;
    logic [WIDTH-1:0] y_next;
    logic [WIDTH-1:0] size_next;
    logic [WIDTH-1:0] result_next;
    logic             gnt0_next;
    logic             gnt1_next;
    logic             busy_next;
    logic             done_next;
    logic             done_id_next;

    // Arbitration winner: rr pointer breaks ties, otherwise the lone requester
    assign win = (req0 && req1) ? rr_ptr : ~req0;

    // Terminal condition is judged on the registered counter, not the next one
    assign x_over = (x > {1'b0, size});

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-value decode for the whole block
    always_comb begin
        state_next   = state;
        rr_next      = rr_ptr;
        owner_next   = owner;
        x_next       = x;
        y_next       = y;
        size_next    = size;
        result_next  = result;
        gnt0_next    = gnt0;
        gnt1_next    = gnt1;
        done_next    = 1'b0;
        done_id_next = done_id;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = RUN;
                    owner_next = win;
                    rr_next    = ~win;
                    size_next  = win ? lim1 : lim0;
                    x_next     = XW'(1);
                    y_next     = '0;
                    gnt0_next  = ~win;
                    gnt1_next  = win;
                end
            end

            RUN: begin
                if (x_over) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    result_next  = y;
                    done_id_next = owner;
                end else if (step_en) begin
                    x_next = x + XW'(1);
                    y_next = y + WIDTH'(1);
                end
            end

            DONE: begin
                state_next = IDLE;
                gnt0_next  = 1'b0;
                gnt1_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                gnt0_next  = 1'b0;
                gnt1_next  = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // Registered outputs and counter datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= 1'b0;
            owner   <= 1'b0;
            x       <= XW'(1);
            y       <= '0;
            size    <= WIDTH'(RESET_SIZE);
            result  <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            rr_ptr  <= rr_next;
            owner   <= owner_next;
            x       <= x_next;
            y       <= y_next;
            size    <= size_next;
            result  <= result_next;
            gnt0    <= gnt0_next;
            gnt1    <= gnt1_next;
            busy    <= busy_next;
            done    <= done_next;
            done_id <= done_id_next;
        end
    end

endmodule

// File: tb/tb_bounded_count_sched.sv
// Randomised and directed bench for bounded_count_sched with a job-level
// reference model feeding grant/done scoreboards and per-cycle invariants.
module tb_bounded_count_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, step_en;
    logic [7:0] lim0, lim1;
    logic       gnt0, gnt1, busy, done, done_id;
    logic [7:0] result, y, size;
    logic [8:0] x;

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;

    bounded_count_sched #(.WIDTH(8), .RESET_SIZE(230)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .lim0(lim0), .req1(req1), .lim1(lim1),
        .step_en(step_en),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .done(done), .done_id(done_id), .result(result),
        .x(x), .y(y), .size(size)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name, input string msg);
        tests++;
        fails++;
        $display("FAIL %s: %s (t=%0t)", name, msg, $time);
    endtask

    // ---------------- reference model (job level) ----------------
    typedef struct {
        int id;
        int val;
    } ev_t;

    ev_t gq[$];
    ev_t dq[$];

    bit m_act   = 0;   // a job owns the counter (includes the completion cycle)
    bit m_fin   = 0;   // completion cycle
    int m_owner = 0;
    int m_lim   = 0;
    int m_steps = 0;   // steps taken by the current/last job
    int m_size  = 230;
    int m_rr    = 0;
    int m_res   = 0;
    int m_did   = 0;

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_act = 0; m_fin = 0; m_owner = 0; m_lim = 0; m_steps = 0;
            m_size = 230; m_rr = 0; m_res = 0; m_did = 0;
            gq.delete();
            dq.delete();
        end else if (m_fin) begin
            m_fin = 0;
            m_act = 0;
        end else if (m_act) begin
            if (m_steps >= m_lim) begin
                m_fin = 1;
                m_res = m_lim;
                m_did = m_owner;
                dq.push_back('{id: m_owner, val: m_lim});
            end else if (step_en) begin
                m_steps++;
            end
        end else if (req0 || req1) begin
            w       = (req0 && req1) ? m_rr : (req0 ? 0 : 1);
            m_rr    = 1 - w;
            m_owner = w;
            m_lim   = w ? int'(lim1) : int'(lim0);
            m_size  = m_lim;
            m_steps = 0;
            m_act   = 1;
            gq.push_back('{id: w, val: m_lim});
        end
    end

    // ---------------- monitor ----------------
    bit prev_g = 0;

    always @(negedge clk) begin
        ev_t e;
        bit  g;
        if (mon_en) begin
            chk("x", int'(x), m_steps + 1);
            chk("y", int'(y), m_steps);
            chk("size", int'(size), m_size);
            chk("gnt0", int'(gnt0), int'(m_act && m_owner == 0));
            chk("gnt1", int'(gnt1), int'(m_act && m_owner == 1));
            chk("busy", int'(busy), int'(m_act));
            chk("done", int'(done), int'(m_fin));
            chk("result", int'(result), m_res);
            chk("done_id", int'(done_id), m_did);

            if (busy) chk("inv_y_eq_x_minus_1", int'(y), int'(x) - 1);
            chk("inv_one_gnt", int'(gnt0 & gnt1), 0);
            if (done) chk("inv_result_eq_size", int'(result), int'(size));
            chk("inv_xy_range", int'(y != 0 && y != size && x > {1'b0, size}), 0);

            g = gnt0 | gnt1;
            if (g && !prev_g) begin
                if (gq.size() == 0) fail_evt("gnt_event", "grant without expected grant");
                else begin
                    e = gq.pop_front();
                    chk("gnt_owner", int'(gnt1), e.id);
                    chk("gnt_size", int'(size), e.val);
                end
            end else if (gq.size() != 0) begin
                fail_evt("gnt_event", "expected grant did not appear");
                gq.delete();
            end
            prev_g = g;

            if (done) begin
                if (dq.size() == 0) fail_evt("done_event", "done without expected completion");
                else begin
                    e = dq.pop_front();
                    chk("done_ev_id", int'(done_id), e.id);
                    chk("done_ev_result", int'(result), e.val);
                end
            end else if (dq.size() != 0) begin
                fail_evt("done_event", "expected done did not appear");
                dq.delete();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_evt("wait_idle", "block stayed busy");
    endtask

    task automatic run_job(input int id, input int lim, input bit toggle,
                           output int lat, output int rid, output int rres, output int maxx);
        bit got;
        wait_idle();
        got = 0; lat = -1; rid = -1; rres = -1; maxx = 0;
        step_en = 1'b1;
        if (id == 0) begin lim0 = 8'(lim); req0 = 1'b1; end
        else         begin lim1 = 8'(lim); req1 = 1'b1; end
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin req0 = 1'b0; req1 = 1'b0; end
            if (toggle) step_en = ~step_en;
            if (int'(x) > maxx) maxx = int'(x);
            if (done) begin
                got = 1; lat = n; rid = int'(done_id); rres = int'(result);
                break;
            end
        end
        step_en = 1'b1;
        if (!got) fail_evt("run_job_timeout", "no done within bound");
    endtask

    task automatic wait_done(output bit got);
        got = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        if (!got) fail_evt("wait_done_timeout", "no done within bound");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, rid, rres, maxx, cnt;
        int exp_id[4];
        int exp_res[4];
        bit got;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; lim0 = '0; lim1 = '0; step_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;

        chk("rst_x", int'(x), 1);
        chk("rst_y", int'(y), 0);
        chk("rst_size", int'(size), 230);
        chk("rst_gnt", int'({gnt1, gnt0}), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_busy", int'(busy), 0);

        // basic job: limit 5
        run_job(0, 5, 0, lat, rid, rres, maxx);
        chk("lim5_latency", lat, 7);
        chk("lim5_result", rres, 5);
        chk("lim5_id", rid, 0);
        chk("lim5_max_x", maxx, 6);

        // both requesters held: alternating grants from a fresh rr pointer
        do_reset();
        exp_id  = '{0, 1, 0, 1};
        exp_res = '{3, 4, 3, 4};
        lim0 = 8'd3; lim1 = 8'd4; req0 = 1'b1; req1 = 1'b1; step_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(got);
            if (got) begin
                chk("rr_order_id", int'(done_id), exp_id[k]);
                chk("rr_order_result", int'(result), exp_res[k]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;

        // zero limit completes without stepping
        run_job(0, 0, 0, lat, rid, rres, maxx);
        chk("lim0_latency", lat, 2);
        chk("lim0_result", rres, 0);
        chk("lim0_max_x", maxx, 1);

        // full-scale limit: x reaches 256 without wrapping
        run_job(1, 255, 0, lat, rid, rres, maxx);
        chk("lim255_latency", lat, 257);
        chk("lim255_result", rres, 255);
        chk("lim255_id", rid, 1);
        chk("lim255_max_x", maxx, 256);

        // step_en toggling: ten stall cycles add ten cycles of latency
        run_job(0, 10, 1, lat, rid, rres, maxx);
        chk("toggle_latency", lat, 22);
        chk("toggle_result", rres, 10);

        // reset in the middle of a job aborts it silently
        wait_idle();
        lim0 = 8'd10; req0 = 1'b1; step_en = 1'b1;
        got = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            req0 = 1'b0;
            if (busy && y == 8'd4) begin got = 1; break; end
        end
        if (!got) fail_evt("abort_setup", "y never reached 4");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_x", int'(x), 1);
        chk("abort_y", int'(y), 0);
        chk("abort_size", int'(size), 230);
        chk("abort_gnt0", int'(gnt0), 0);
        chk("abort_done", int'(done), 0);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 399) == 0);
            req0    = ($urandom_range(0, 2) == 0);
            req1    = ($urandom_range(0, 2) == 0);
            lim0    = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            lim1    = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 12));
            step_en = ($urandom_range(0, 3) != 0);
        end

        // drain
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; step_en = 1'b1;
        @(negedge clk);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("drain_done_queue", dq.size(), 0);
        chk("drain_grant_queue", gq.size(), 0);

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
